keccak_sponge_ctrl: RTL and testbench
=====================================

Name: keccak_sponge_ctrl

Overview:
- Sequencer for the Keccak-f[1600] sponge datapath: VSX absorb stage, state register, lane re-mapping and round logic.
- Latches the hash mode, clears the state, and accepts rate-sized message blocks over a valid/ready handshake.
- Issues absorb, round and squeeze strobes, and tracks the round index.
- Sits between the host interface and the 1600-bit state register; it holds no data-path bits itself.

Parameters:
- NR, 24, number of Keccak-f rounds per permutation.
- RPC, 1, rounds computed per clock by the round logic; legal values 1, 2, 3, 4, 6 (must divide NR).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin new hash; sampled only in IDLE.
- c_mode  input  3  mode select: 0 SHA3-224, 1 SHA3-256, 2 SHA3-384, 3 SHA3-512, 4 SHAKE128, 5 SHAKE256; 6 and 7 are illegal.
- blk_valid  input  1  a padded message block is present on the VSX data input.
- blk_last  input  1  the current block is the final absorb block.
- blk_ready  output  1  controller accepts a block this cycle.
- squeeze_more  input  1  SHAKE only: request another output block; sampled on the out handshake.
- out_valid  output  1  state holds a valid digest or squeeze block.
- out_ready  input  1  consumer takes the output block.
- mode_q  output  3  latched mode, drives VSX c_mode.
- rate_lanes  output  5  rate in 64-bit lanes for mode_q: 18, 17, 13, 9, 21, 17.
- st_init  output  1  clear the state register.
- st_absorb  output  1  load the VSX result into the state register.
- st_round  output  1  apply RPC rounds starting at round_idx.
- round_idx  output  5  index of the first round applied this cycle.
- busy  output  1  high when not in IDLE.
- err  output  1  one-cycle pulse on an illegal start.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset, effective at any state including mid-permutation or mid-squeeze:
  - state IDLE.
  - mode_q=0, round_idx=0, internal last flag=0.
  - Every output is 0 except rate_lanes, which decodes mode_q=0 to 18.
- States: IDLE, INIT, WAIT_BLK, PERMUTE, SQUEEZE.
- IDLE:
  - start with c_mode<=5: latch mode_q, go to INIT.
  - start with c_mode>=6: err=1 for the next cycle only, stay in IDLE, mode_q unchanged.
- INIT:
  - st_init=1 (registered one-cycle pulse), then go to WAIT_BLK.
- WAIT_BLK:
  - blk_ready=1.
  - On blk_valid: st_absorb=1 combinationally in the same cycle; latch blk_last; round_idx<=0; go to PERMUTE.
- PERMUTE:
  - st_round=1 every cycle; round_idx advances by RPC each cycle.
  - In the cycle where round_idx==NR-RPC, exit: to SQUEEZE if the last flag is set, else to WAIT_BLK.
  - Length is exactly NR/RPC cycles.
- SQUEEZE:
  - out_valid=1 and held until out_ready.
  - On out_ready with mode_q in {4,5} and squeeze_more=1: round_idx<=0, go to PERMUTE (last flag stays 1).
  - On out_ready otherwise: go to IDLE. squeeze_more is ignored for SHA3 modes.
- Latency:
  - Block accepted at cycle T gives st_round in cycles T+1..T+NR/RPC.
  - The next blk_ready (non-last) or out_valid (last) comes at T+NR/RPC+1.
  - For NR=24, RPC=1 this is T+25.
  - start at cycle S: st_init at S+1, first blk_ready at S+2.
- Strobe exclusivity: st_init, st_absorb, st_round and out_valid are mutually exclusive.
- Handshake rules:
  - blk_valid outside WAIT_BLK has no effect and is not dropped; the host holds it.
  - blk_last is meaningful only with blk_valid.
- busy and start:
  - busy=1 in every state except IDLE.
  - start while busy is ignored.
- rate_lanes: combinational decode of mode_q.
- round_idx wrap: never exceeds NR-RPC; it holds its last value outside PERMUTE until the next absorb or squeeze reload.

Test Plan:
- Reset then start, c_mode=1, single block with blk_last=1 at cycle T -> st_init one cycle; blk_ready two cycles after start; st_round T+1..T+24 with round_idx 0..23; out_valid at T+25; rate_lanes=17; IDLE after out_ready.
- Three blocks, c_mode=4, blk_valid delayed 3 cycles between blocks -> 3×24 st_round cycles; blk_ready high only in WAIT_BLK; out_valid only after the third block.
- SHAKE256 squeeze: out_ready with squeeze_more=1 twice, then 0 -> two extra 24-cycle permutations, three out_valid handshakes, then IDLE. Repeating with c_mode=0 and squeeze_more=1 -> IDLE after the first output.
- start with c_mode=7 -> err pulse of exactly 1 cycle; busy stays 0; no st_init.
- rst asserted at round_idx=10 mid-PERMUTE -> next cycle all strobes 0, round_idx=0, IDLE; a following start runs normally.
- RPC=4 build, single block -> 6 st_round cycles with round_idx 0, 4, 8, 12, 16, 20; out_valid at T+7.

Source files
------------

// File: rtl/keccak_sponge_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : keccak_sponge_ctrl
// Description : Sequencer for the Keccak-f[1600] sponge datapath: mode latch,
//               block absorb handshake, round strobes and squeeze control.
// Revision    : 1.0 - initial release
// ============================================================================
module keccak_sponge_ctrl #(
    parameter int NR  = 24,
    parameter int RPC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] c_mode,
    input  logic       blk_valid,
    input  logic       blk_last,
    output logic       blk_ready,
    input  logic       squeeze_more,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] mode_q,
    output logic [4:0] rate_lanes,
    output logic       st_init,
    output logic       st_absorb,
    output logic       st_round,
    output logic [4:0] round_idx,
    output logic       busy,
    output logic       err
);

    localparam logic [4:0] C_RPC        = 5'(RPC);
    localparam logic [4:0] C_LAST_ROUND = 5'(NR - RPC);
    localparam logic [2:0] C_MAX_MODE   = 3'd5;
    localparam logic [2:0] C_SHAKE128   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INIT     = 3'd1,
        S_WAIT_BLK = 3'd2,
        S_PERMUTE  = 3'd3,
        S_SQUEEZE  = 3'd4
    } state_t;

    state_t     r_state;
    logic [2:0] r_mode;
    logic [4:0] r_round_idx;
    logic       r_last;
    logic       r_err;
    logic [4:0] w_rate;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mode      <= 3'd0;
            r_round_idx <= 5'd0;
            r_last      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (c_mode <= C_MAX_MODE) begin
                            r_mode  <= c_mode;
                            r_state <= S_INIT;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_INIT: begin
                    r_state <= S_WAIT_BLK;
                end
                S_WAIT_BLK: begin
                    if (blk_valid) begin
                        r_last      <= blk_last;
                        r_round_idx <= 5'd0;
                        r_state     <= S_PERMUTE;
                    end
                end
                S_PERMUTE: begin
                    // round_idx parks on the final round index until reloaded
                    if (r_round_idx == C_LAST_ROUND) begin
                        r_state <= r_last ? S_SQUEEZE : S_WAIT_BLK;
                    end else begin
                        r_round_idx <= r_round_idx + C_RPC;
                    end
                end
                S_SQUEEZE: begin
                    if (out_ready) begin
                        if ((r_mode >= C_SHAKE128) && squeeze_more) begin
                            r_round_idx <= 5'd0;
                            r_state     <= S_PERMUTE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_rate = 5'd18;
        case (r_mode)
            3'd0:    w_rate = 5'd18;
            3'd1:    w_rate = 5'd17;
            3'd2:    w_rate = 5'd13;
            3'd3:    w_rate = 5'd9;
            3'd4:    w_rate = 5'd21;
            3'd5:    w_rate = 5'd17;
            default: w_rate = 5'd0;
        endcase
    end

    assign blk_ready  = (r_state == S_WAIT_BLK);
    assign st_absorb  = (r_state == S_WAIT_BLK) && blk_valid;
    assign st_init    = (r_state == S_INIT);
    assign st_round   = (r_state == S_PERMUTE);
    assign out_valid  = (r_state == S_SQUEEZE);
    assign busy       = (r_state != S_IDLE);
    assign err        = r_err;
    assign mode_q     = r_mode;
    assign round_idx  = r_round_idx;
    assign rate_lanes = w_rate;

endmodule
`default_nettype wire

// File: tb/tb_keccak_sponge_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_keccak_sponge_ctrl
// Description : Self-checking bench for keccak_sponge_ctrl (RPC=1 and RPC=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keccak_sponge_ctrl;

    localparam int NR   = 24;
    localparam int RPC  = 1;
    localparam int NCYC = NR / RPC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, blk_valid, blk_last, squeeze_more, out_ready;
    logic [2:0] c_mode;
    logic       blk_ready, out_valid, st_init, st_absorb, st_round, busy, err;
    logic [2:0] mode_q;
    logic [4:0] rate_lanes, round_idx;

    logic       start4, blk_valid4, blk_last4, squeeze_more4, out_ready4;
    logic [2:0] c_mode4;
    logic       blk_ready4, out_valid4, st_init4, st_absorb4, st_round4, busy4, err4;
    logic [2:0] mode_q4;
    logic [4:0] rate_lanes4, round_idx4;

    keccak_sponge_ctrl #(.NR(NR), .RPC(RPC)) u_dut (
        .clk(clk), .rst(rst), .start(start), .c_mode(c_mode),
        .blk_valid(blk_valid), .blk_last(blk_last), .blk_ready(blk_ready),
        .squeeze_more(squeeze_more), .out_valid(out_valid), .out_ready(out_ready),
        .mode_q(mode_q), .rate_lanes(rate_lanes), .st_init(st_init),
        .st_absorb(st_absorb), .st_round(st_round), .round_idx(round_idx),
        .busy(busy), .err(err)
    );

    keccak_sponge_ctrl #(.NR(24), .RPC(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .c_mode(c_mode4),
        .blk_valid(blk_valid4), .blk_last(blk_last4), .blk_ready(blk_ready4),
        .squeeze_more(squeeze_more4), .out_valid(out_valid4), .out_ready(out_ready4),
        .mode_q(mode_q4), .rate_lanes(rate_lanes4), .st_init(st_init4),
        .st_absorb(st_absorb4), .st_round(st_round4), .round_idx(round_idx4),
        .busy(busy4), .err(err4)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Rate follows from capacity = twice the digest/security size.
    function automatic int rate_of(input int mode);
        int cap [0:5];
        cap = '{448, 512, 768, 1024, 256, 512};
        return (1600 - cap[mode]) / 64;
    endfunction

    // Transaction-level model: phases tracked as flags plus a rounds-left count.
    bit m_valid = 0, m_init = 0, m_wait = 0, m_out = 0, m_last = 0, m_err = 0;
    int m_left = 0, m_round = 0, m_mode = 0;

    task automatic model_step();
        bit idle;
        if (rst) begin
            m_valid = 1; m_init = 0; m_wait = 0; m_out = 0; m_last = 0; m_err = 0;
            m_left = 0; m_round = 0; m_mode = 0;
        end else if (m_valid) begin
            idle  = !(m_init || m_wait || m_out || (m_left > 0));
            m_err = 0;
            if (idle) begin
                if (start) begin
                    if (int'(c_mode) <= 5) begin m_mode = int'(c_mode); m_init = 1; end
                    else m_err = 1;
                end
            end else if (m_init) begin
                m_init = 0; m_wait = 1;
            end else if (m_wait) begin
                if (blk_valid) begin m_wait = 0; m_last = blk_last; m_left = NCYC; end
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_last) m_out = 1; else m_wait = 1;
                end
            end else if (m_out && out_ready) begin
                m_out = 0;
                if (m_mode >= 4 && squeeze_more) m_left = NCYC;
            end
            if (m_left > 0) m_round = (NCYC - m_left) * RPC;
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy",       busy,       (m_init || m_wait || m_out || m_left > 0) ? 1 : 0);
            chk("st_init",    st_init,    m_init);
            chk("blk_ready",  blk_ready,  m_wait);
            chk("st_absorb",  st_absorb,  (m_wait && blk_valid) ? 1 : 0);
            chk("st_round",   st_round,   (m_left > 0) ? 1 : 0);
            chk("round_idx",  round_idx,  m_round);
            chk("out_valid",  out_valid,  m_out);
            chk("err",        err,        m_err);
            chk("mode_q",     mode_q,     m_mode);
            chk("rate_lanes", rate_lanes, rate_of(m_mode));
            chk("strobe_excl", ($countones({st_init, st_absorb, st_round, out_valid}) <= 1) ? 1 : 0, 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_hash(input int mode);
        start = 1'b1; c_mode = 3'(mode);
        tick();
        start = 1'b0;
        chk("st_init_after_start", st_init, 1);
        tick();
        chk("blk_ready_start_plus2", blk_ready, 1);
    endtask

    task automatic count_rounds(output int n);
        n = 0;
        while (st_round && n < 100) begin
            chk("round_idx_seq", round_idx, n * RPC);
            n++;
            tick();
        end
    endtask

    task automatic send_block(input bit last, input int gap, output int rounds);
        int i;
        i = 0;
        while (!blk_ready && i < 100) begin i++; tick(); end
        chk("wait_blk_ready", blk_ready, 1);
        repeat (gap) tick();
        chk("blk_ready_held", blk_ready, 1);
        blk_valid = 1'b1; blk_last = last;
        tick();
        blk_valid = 1'b0; blk_last = 1'b0;
        count_rounds(rounds);
    endtask

    task automatic take_out(input bit more);
        chk("out_valid_before_take", out_valid, 1);
        out_ready = 1'b1; squeeze_more = more;
        tick();
        out_ready = 1'b0; squeeze_more = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, outs;
        rst = 1; start = 0; c_mode = 0; blk_valid = 0; blk_last = 0;
        squeeze_more = 0; out_ready = 0;
        start4 = 0; c_mode4 = 0; blk_valid4 = 0; blk_last4 = 0;
        squeeze_more4 = 0; out_ready4 = 0;
        tick(); tick();
        chk("reset_busy", busy, 0);
        chk("reset_rate", rate_lanes, 18);
        chk("reset_round_idx", round_idx, 0);
        chk("reset_mode", mode_q, 0);
        rst = 0;
        tick();

        // SHA3-256 single block: 24 rounds then digest
        start_hash(1);
        send_block(1'b1, 0, n);
        chk("t1_rounds", n, 24);
        chk("t1_out_valid_T25", out_valid, 1);
        chk("t1_rate", rate_lanes, 17);
        take_out(1'b1);
        chk("t1_idle", busy, 0);
        tick();

        // SHAKE128, three blocks with a 3-cycle host gap
        start_hash(4);
        send_block(1'b0, 3, n);
        chk("t2_rounds_b1", n, 24);
        chk("t2_no_out_b1", out_valid, 0);
        send_block(1'b0, 3, n);
        chk("t2_rounds_b2", n, 24);
        chk("t2_no_out_b2", out_valid, 0);
        send_block(1'b1, 3, n);
        chk("t2_rounds_b3", n, 24);
        chk("t2_out_b3", out_valid, 1);
        chk("t2_rate", rate_lanes, 21);
        take_out(1'b0);
        chk("t2_idle", busy, 0);

        // SHAKE256 multi-squeeze
        start_hash(5);
        send_block(1'b1, 1, n);
        outs = 0;
        for (int s = 0; s < 2; s++) begin
            take_out(1'b1); outs++;
            count_rounds(k);
            chk("t3_squeeze_rounds", k, 24);
        end
        take_out(1'b0); outs++;
        chk("t3_out_count", outs, 3);
        chk("t3_idle", busy, 0);

        // SHA3-224 ignores squeeze_more
        start_hash(0);
        send_block(1'b1, 0, n);
        take_out(1'b1);
        chk("t3b_idle", busy, 0);
        chk("t3b_no_round", st_round, 0);

        // Illegal mode
        tick();
        start = 1'b1; c_mode = 3'd7;
        tick();
        start = 1'b0;
        chk("t4_err", err, 1);
        chk("t4_busy", busy, 0);
        chk("t4_no_init", st_init, 0);
        chk("t4_mode_kept", mode_q, 0);
        tick();
        chk("t4_err_one_cycle", err, 0);

        // Reset mid-permutation
        start_hash(2);
        blk_valid = 1'b1; blk_last = 1'b1;
        tick();
        blk_valid = 1'b0; blk_last = 1'b0;
        k = 0;
        while (round_idx != 5'd10 && k < 100) begin k++; tick(); end
        chk("t5_reached_10", round_idx, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_round_cleared", st_round, 0);
        chk("t5_idx_cleared", round_idx, 0);
        chk("t5_idle", busy, 0);
        chk("t5_mode_cleared", mode_q, 0);
        start_hash(3);
        chk("t5_rate", rate_lanes, 9);
        send_block(1'b1, 0, n);
        chk("t5_rounds", n, 24);
        take_out(1'b0);
        chk("t5_done_idle", busy, 0);

        // RPC=4 instance: 6 rounds stepping by 4
        start4 = 1'b1; c_mode4 = 3'd0;
        tick();
        start4 = 1'b0;
        chk("r4_init", st_init4, 1);
        tick();
        chk("r4_ready", blk_ready4, 1);
        blk_valid4 = 1'b1; blk_last4 = 1'b1;
        tick();
        blk_valid4 = 1'b0; blk_last4 = 1'b0;
        n = 0;
        while (st_round4 && n < 100) begin
            chk("r4_round_idx", round_idx4, n * 4);
            n++;
            tick();
        end
        chk("r4_rounds", n, 6);
        chk("r4_out_T7", out_valid4, 1);
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        chk("r4_idle", busy4, 0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
